// File: rtl/npu_pkg.sv
// Shared NPU definitions: instruction encoding, load-mode codes used by the
// scheduler, and the decoder FSM state type.
package npu_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_LOAD    = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_SYNC    = 2'b11
  } opcode_e;

  localparam logic [1:0] LOAD_IDLE = 2'd0;
  localparam logic [1:0] LOAD_A    = 2'd1;
  localparam logic [1:0] LOAD_B    = 2'd2;
  localparam logic [1:0] LOAD_C    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_SYNC
  } dec_state_e;

  // Instruction field bit positions
  localparam int OPC_HI    = 7;
  localparam int OPC_LO    = 6;
  localparam int MODE_HI   = 5;
  localparam int MODE_LO   = 4;
  localparam int RELU_BIT  = 5;
  localparam int BCAST_BIT = 4;
  localparam int REP_LO    = 0;

endpackage

// File: rtl/npu_instr_fifo.sv
// Small show-ahead instruction FIFO; pointers carry an extra wrap bit so
// full/empty/level fall straight out of the pointer difference.
module npu_instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read between valid pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/npu_instr_decoder.sv
// NPU instruction front-end: buffers instructions, decodes them and issues
// one scheduler pass per repeat beat, paced by the scheduler's idle flag.
module npu_instr_decoder
  import npu_pkg::*;
#(
  parameter int W_IN       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [W_IN-1:0]               instr,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic                          sched_idle,
  output logic                          start,
  output logic [1:0]                    load_mode,
  output logic                          compute_en,
  output logic                          broadcast_en,
  output logic                          relu_en,
  output logic                          busy,
  output logic                          sync_done,
  output logic                          illegal_err,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0]    LEVEL_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  dec_state_e       state_reg, state_next, after_done;
  logic [W_IN-1:0]  head;
  logic             fifo_full, fifo_empty, push, pop;
  opcode_e          head_op;
  logic             head_illegal, head_issues, more_after_pop;
  logic [CNT_W-1:0] rep_cnt_reg;
  logic [1:0]       load_mode_reg;
  logic             compute_en_reg, broadcast_en_reg, relu_en_reg, illegal_err_reg;

  assign instr_ready = !fifo_full;
  assign push        = instr_valid && instr_ready;

  npu_instr_fifo #(
    .WIDTH (W_IN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (instr),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head_op        = opcode_e'(head[OPC_HI:OPC_LO]);
  assign head_illegal   = (head_op == OP_LOAD) && (head[MODE_HI:MODE_LO] == LOAD_IDLE);
  assign head_issues    = ((head_op == OP_LOAD) && !head_illegal) || (head_op == OP_COMPUTE);
  assign more_after_pop = (fifo_level > LEVEL_ONE);
  assign after_done     = fifo_empty ? ST_IDLE : ST_DECODE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (!fifo_empty) state_next = ST_DECODE;
      ST_DECODE: begin
        if (head_op == OP_SYNC) state_next = ST_SYNC;
        else if (head_issues)   state_next = ST_ISSUE;
        else                    state_next = more_after_pop ? ST_DECODE : ST_IDLE;
      end
      ST_ISSUE:  if (sched_idle) state_next = ST_WAIT;
      ST_WAIT:   if (sched_idle) state_next = (rep_cnt_reg != '0) ? ST_ISSUE : after_done;
      ST_SYNC:   if (sched_idle) state_next = after_done;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start     = 1'b0;
    sync_done = 1'b0;
    pop       = 1'b0;
    case (state_reg)
      ST_DECODE: pop       = 1'b1;
      ST_ISSUE:  start     = sched_idle;
      ST_SYNC:   sync_done = sched_idle;
      default:   ;
    endcase
  end

  // Controls are captured once per instruction and held across all repeats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_reg      <= '0;
      load_mode_reg    <= LOAD_IDLE;
      compute_en_reg   <= 1'b0;
      broadcast_en_reg <= 1'b0;
      relu_en_reg      <= 1'b0;
    end else if (state_reg == ST_DECODE) begin
      rep_cnt_reg      <= head_issues ? head[REP_LO +: CNT_W] : '0;
      load_mode_reg    <= (head_op == OP_LOAD) ? head[MODE_HI:MODE_LO] : LOAD_IDLE;
      compute_en_reg   <= (head_op == OP_COMPUTE);
      broadcast_en_reg <= (head_op == OP_COMPUTE) && head[BCAST_BIT];
      relu_en_reg      <= (head_op == OP_COMPUTE) && head[RELU_BIT];
    end else begin
      if ((state_reg == ST_WAIT) && sched_idle && (rep_cnt_reg != '0))
        rep_cnt_reg <= rep_cnt_reg - CNT_ONE;
      if (state_next == ST_IDLE) begin
        load_mode_reg    <= LOAD_IDLE;
        compute_en_reg   <= 1'b0;
        broadcast_en_reg <= 1'b0;
        relu_en_reg      <= 1'b0;
      end
    end
  end

  // A new illegal instruction wins over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          illegal_err_reg <= 1'b0;
    else if ((state_reg == ST_DECODE) && head_illegal)   illegal_err_reg <= 1'b1;
    else if (err_clr)                                    illegal_err_reg <= 1'b0;
  end

  assign load_mode    = load_mode_reg;
  assign compute_en   = compute_en_reg;
  assign broadcast_en = broadcast_en_reg;
  assign relu_en      = relu_en_reg;
  assign illegal_err  = illegal_err_reg;
  assign busy         = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_npu_instr_decoder.sv
// Bench for npu_instr_decoder: a vector table of single instructions plus
// hand-written multi-cycle sequences, against a 4-cycle scheduler model.
module tb_npu_instr_decoder;

  localparam int W_IN       = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int SCHED_LAT  = 4;
  localparam int NV         = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W_IN-1:0] instr = '0;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic            sched_idle = 1'b1;
  logic            start;
  logic [1:0]      load_mode;
  logic            compute_en, broadcast_en, relu_en, busy, sync_done, illegal_err;
  logic            err_clr = 1'b0;
  logic [LW-1:0]   fifo_level;

  always #5 clk = ~clk;

  npu_instr_decoder #(
    .W_IN       (W_IN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .sched_idle   (sched_idle),
    .start        (start),
    .load_mode    (load_mode),
    .compute_en   (compute_en),
    .broadcast_en (broadcast_en),
    .relu_en      (relu_en),
    .busy         (busy),
    .sync_done    (sync_done),
    .illegal_err  (illegal_err),
    .err_clr      (err_clr),
    .fifo_level   (fifo_level)
  );

  // {is_sync, load_mode, compute_en, broadcast_en, relu_en}
  typedef struct packed {
    logic       is_sync;
    logic [1:0] lm;
    logic       ce;
    logic       be;
    logic       re;
  } exp_t;

  typedef struct {
    logic [7:0] w;
    exp_t       e;
    int         starts;
    int         syncs;
    logic       ill;
  } vec_t;

  exp_t    sb_q[$];
  exp_t    hold_exp;
  logic    hold_active = 1'b0;
  vec_t    vecs[NV];
  int      checks = 0;
  int      errors = 0;
  int      start_cnt = 0, sync_cnt = 0, cyc = 0;
  int      last_start_cyc = 0, last_sync_cyc = 0;
  logic    sched_auto = 1'b1, sched_force = 1'b1;
  int      sched_cnt = 0;
  logic    acc = 1'b0;
  logic [LW-1:0] lvl_s = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs at negedge, then advance the scheduler model after posedge
  task automatic tick();
    exp_t obs, e;
    logic s;
    @(negedge clk);
    cyc++;
    s     = start;
    acc   = instr_valid && instr_ready;
    lvl_s = fifo_level;
    obs   = {1'b0, load_mode, compute_en, broadcast_en, relu_en};
    if (hold_active) chk("ctl_hold", obs, hold_exp);
    if (start) begin
      start_cnt++;
      last_start_cyc = cyc;
      chk("start_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("start_ctl", obs, e);
        hold_exp    = e;
        hold_active = (sb_q.size() > 0) && (sb_q[0] == e);
      end
    end
    if (sync_done) begin
      sync_cnt++;
      last_sync_cyc = cyc;
      chk("sync_while_idle", sched_idle, 1);
      chk("sync_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sync_kind", e.is_sync, 1);
      end
    end
    @(posedge clk);
    #1;
    if (sched_cnt > 0) sched_cnt--;
    if (s) sched_cnt = SCHED_LAT;
    sched_idle = sched_auto ? (sched_cnt == 0) : sched_force;
  endtask

  task automatic set_sched(input logic auto_mode, input logic force_val);
    sched_auto  = auto_mode;
    sched_force = force_val;
    sched_idle  = auto_mode ? (sched_cnt == 0) : force_val;
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    instr       = w;
    instr_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc && n < 50);
    instr_valid = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic expect_n(input exp_t e, input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((busy || !sched_idle) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_in_time", n < limit, 1);
    repeat (2) tick();
  endtask

  initial begin
    int s0, y0, n, k;
    logic [7:0] words[5];

    vecs[0]  = '{8'h62, 6'b010000,  3, 0, 1'b0};
    vecs[1]  = '{8'hB0, 6'b000111,  1, 0, 1'b0};
    vecs[2]  = '{8'h51, 6'b001000,  2, 0, 1'b0};
    vecs[3]  = '{8'h70, 6'b011000,  1, 0, 1'b0};
    vecs[4]  = '{8'h8F, 6'b000100, 16, 0, 1'b0};
    vecs[5]  = '{8'hA1, 6'b000101,  2, 0, 1'b0};
    vecs[6]  = '{8'h92, 6'b000110,  3, 0, 1'b0};
    vecs[7]  = '{8'h00, 6'b000000,  0, 0, 1'b0};
    vecs[8]  = '{8'h40, 6'b000000,  0, 0, 1'b1};
    vecs[9]  = '{8'hC0, 6'b100000,  0, 1, 1'b0};
    vecs[10] = '{8'hFF, 6'b100000,  0, 1, 1'b0};
    vecs[11] = '{8'h3F, 6'b000000,  0, 0, 1'b0};

    // Reset state
    repeat (3) tick();
    chk("rst_ready", instr_ready, 1);
    chk("rst_ctl", {start, load_mode, compute_en, broadcast_en, relu_en}, 0);
    chk("rst_flags", {busy, sync_done, illegal_err}, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    tick();

    // Accept in c0 -> start in c3
    sb_q.push_back(6'b000111);
    s0 = start_cnt;
    instr = 8'hB0;
    instr_valid = 1'b1;
    tick();
    chk("lat_accept", acc, 1);
    instr_valid = 1'b0;
    n = 0;
    while (start_cnt == s0 && n < 10) begin
      tick();
      n++;
    end
    chk("latency", n, 3);
    drain(100);

    // Vector table: one instruction at a time, run to completion
    for (int i = 0; i < NV; i++) begin
      s0 = start_cnt;
      y0 = sync_cnt;
      expect_n(vecs[i].e, vecs[i].starts);
      if (vecs[i].syncs > 0) sb_q.push_back(vecs[i].e);
      send(vecs[i].w);
      drain(400);
      chk($sformatf("v%0d_starts", i), start_cnt - s0, vecs[i].starts);
      chk($sformatf("v%0d_syncs", i), sync_cnt - y0, vecs[i].syncs);
      chk($sformatf("v%0d_illegal", i), illegal_err, vecs[i].ill);
      chk($sformatf("v%0d_cleared", i), {load_mode, compute_en, broadcast_en, relu_en}, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_sb_empty", i), sb_q.size(), 0);
      if (vecs[i].ill) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk($sformatf("v%0d_err_clr", i), illegal_err, 0);
      end
    end

    // Illegal LOAD then NOP; clear; then set and clear in the same cycle
    s0 = start_cnt;
    send(8'h40);
    send(8'h00);
    drain(100);
    chk("ill_seq_flag", illegal_err, 1);
    chk("ill_seq_nostart", start_cnt - s0, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill_seq_clr", illegal_err, 0);
    send(8'h40);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("set_over_clr", illegal_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_after_set", illegal_err, 0);
    drain(100);

    // FIFO fill: decoder parked in ISSUE while the scheduler is held busy
    s0 = start_cnt;
    set_sched(1'b0, 1'b0);
    sb_q.push_back(6'b000110);
    send(8'h90);
    repeat (3) tick();
    chk("park_level", fifo_level, 0);
    words[0] = 8'h51; words[1] = 8'h62; words[2] = 8'h70; words[3] = 8'h92; words[4] = 8'hA1;
    expect_n(6'b001000, 2);
    expect_n(6'b010000, 3);
    expect_n(6'b011000, 1);
    expect_n(6'b000110, 3);
    expect_n(6'b000101, 2);
    k = 0;
    instr = words[0];
    instr_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (acc) begin
        chk("acc_not_full", lvl_s < FIFO_DEPTH, 1);
        k++;
        if (k < 5) instr = words[k];
      end
    end
    chk("fill_accepts", k, 4);
    chk("fill_level", fifo_level, 4);
    chk("fill_ready", instr_ready, 0);
    chk("fill_no_start", start_cnt - s0, 0);
    set_sched(1'b1, 1'b1);
    n = 0;
    while (k < 5 && n < 40) begin
      tick();
      n++;
      if (acc) begin
        chk("acc_not_full", lvl_s < FIFO_DEPTH, 1);
        k++;
      end
    end
    instr_valid = 1'b0;
    chk("fifth_accept", k, 5);
    chk("fifth_after_issue", start_cnt - s0 >= 1, 1);
    drain(600);
    chk("fill_total_starts", start_cnt - s0, 12);
    chk("fill_sb_empty", sb_q.size(), 0);

    // SYNC behind a 2-repeat COMPUTE
    s0 = start_cnt;
    y0 = sync_cnt;
    expect_n(6'b000100, 2);
    sb_q.push_back(6'b100000);
    send(8'h81);
    send(8'hC0);
    drain(200);
    chk("sync_starts", start_cnt - s0, 2);
    chk("sync_once", sync_cnt - y0, 1);
    chk("sync_cycle", last_sync_cyc - last_start_cyc, 7);

    // SYNC while the scheduler is held busy fires on the first idle cycle
    y0 = sync_cnt;
    set_sched(1'b0, 1'b0);
    sb_q.push_back(6'b100000);
    send(8'hC0);
    repeat (8) tick();
    chk("sync_held", sync_cnt - y0, 0);
    set_sched(1'b1, 1'b1);
    tick();
    chk("sync_first_idle", sync_cnt - y0, 1);
    drain(100);

    // Async reset during WAIT of a 4-repeat LOAD A with more queued behind it
    s0 = start_cnt;
    expect_n(6'b001000, 4);
    send(8'h53);
    send(8'h70);
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_test_first_start", start_cnt - s0, 1);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {start, load_mode, compute_en, broadcast_en, relu_en}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_ready", instr_ready, 1);
    sb_q.delete();
    hold_active = 1'b0;
    tick();
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (40) tick();
    chk("no_starts_after_rst", start_cnt - s0, 0);
    chk("idle_after_rst", busy, 0);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
